vc8000d_g2_hevc_ref_sample_subst_lu: RTL and testbench
======================================================

Name: vc8000d_g2_hevc_ref_sample_subst_lu

Overview:
Consumes the 33-bit luma neighbor-availability vector produced per TU by the neighbor-flag stage and builds the HEVC intra reference sample array, applying spec substitution (clause 8.4.4.2.2). It fetches available 4-sample units from the neighbor line/column buffer and replicates or defaults unavailable ones. Output is streamed unit-by-unit, in scan order, to the reference filter / intra predictor.

Parameters:
PW, 10, pixel width in bits (max bit depth)
LAT, 1, fixed neighbor-buffer read latency in cycles (supported: 1 or 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start_valid  in  1  TU job request
start_ready  out  1  block idle and able to accept a job
neighbor_flags  in  33  [15:0] left units, bit0 = bottom-most; [16] corner; [32:17] above units, bit17 = leftmost
tu_size_4x4  in  4  TU size in 4x4 units: 1, 2, 4 or 8
bit_depth  in  4  active bit depth, 8..PW
rd_req  out  1  neighbor buffer read strobe
rd_idx  out  6  flag-bit index of the unit read
rd_data  in  4*PW  unit samples, lane0 first in scan order; rd_data is valid LAT cycles after rd_req
out_valid  out  1  output unit valid
out_ready  in  1  downstream accept
out_data  out  4*PW  substituted unit, lane0 first in scan order
out_idx  out  6  flag-bit index of the unit
out_last  out  1  final unit of the TU

Behaviour:
- Reset: start_ready=1, out_valid=0, rd_req=0, out_last=0, out_data=0, out_idx=0; FSM=IDLE. Reset mid-job aborts the job with no further output.
- Active range for n=tu_size_4x4: left bits 16-2n..15, corner bit 16, above bits 17..16+2n. Total units U=4n+1. Other values of tu_size_4x4 are treated as 8.
- Corner unit carries one sample in lane0. Its output replicates that value to all 4 lanes. Its "last sample" is lane0. For all other units the last sample is lane3.
- Accept: start_valid&&start_ready latches flags, n and bit_depth. start_ready drops the following cycle.
- A priority encoder finds f, the lowest set active bit.
- FSM states and transitions:
  - IDLE -> NONE if no active bit is set.
  - IDLE -> PRIME otherwise.
  - NONE: emits all U units, start to end, with every lane = 1<<(bit_depth-1). No reads are issued.
  - PRIME: issues rd_req for f. After LAT cycles, last_reg = lane0 of rd_data. Then go to WALK with cur = start.
  - WALK: for unit cur:
    - If its flag is set, issue rd_req(cur), wait LAT cycles, load the output register with rd_data, and set last_reg = last sample.
    - If its flag is clear, load the output register with 4 copies of last_reg; no read is issued.
  - HOLD: out_valid=1 until out_ready. cur then advances, skipping the inactive index gap. After the end unit (16+2n), out_last is asserted with that unit and the FSM returns to IDLE.
- Only one output unit is in flight. A read is never issued while out_valid&&!out_ready.
- The sample for unit f is read twice (PRIME and WALK). This is intentional; it keeps the datapath single-ported.
- Per-unit cost: available unit takes 1+LAT cycles; unavailable unit takes 1 cycle.
- The default value width is PW, computed from bit_depth; bits above bit_depth are zero.
- out_data and out_idx are stable while out_valid&&!out_ready.
- start_valid asserted outside IDLE is ignored.

Optional Feature:
VC8000D_REF_SUBST_STATS_EN:
- When defined, adds output subst_cnt[5:0], the number of unavailable active units in the last completed job. It updates in the cycle out_last handshakes and resets to 0.
- When undefined, the port and counter are absent.

Decomposition:
- Shared package vc8000d_g2_hevc_intra_pkg holds:
  - the FSM state enum (IDLE, NONE, PRIME, WALK, HOLD);
  - flag-index constants LEFT_TOP_IDX=15, CORNER_IDX=16, ABOVE_LEFT_IDX=17;
  - a function returning start and end indices from tu_size_4x4.
- One sub-module, vc8000d_g2_hevc_flag_prio_enc: 33-bit masked lowest-set-bit encoder with an any-set flag.

Test Plan:
- n=1, bit_depth=8, flags=0 -> 5 units, indices 14,15,16,17,18, all lanes 0x80; zero rd_req; out_last on idx 18.
- n=1, flags with only bit17 set, rd_data(17)={lanes 0..3 = 10,11,12,13} -> idx14,15,16 = all 10; idx17 = 10,11,12,13; idx18 = all 13; two reads of idx17.
- n=2, all active flags set, ramp data -> 9 units output unchanged; corner replicated 4x; 10 rd_req total (PRIME + 9).
- n=8, alternating flags, out_ready toggling 1/0 every cycle -> data held stable during stalls; substitution carries the last sample across each gap; out_last on idx 32.
- Reset asserted in HOLD state -> next cycle out_valid=0, start_ready=1; next job completes correctly.
- STATS_EN build, n=4 with 6 active flags clear -> subst_cnt=6 after out_last.

Source files
------------

// File: rtl/vc8000d_g2_hevc_intra_pkg.sv
// Shared HEVC intra types: substitution FSM states, flag indices, TU range.
// Used by the luma reference-sample substitution block.
package vc8000d_g2_hevc_intra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NONE,
    PRIME,
    WALK,
    HOLD
  } subst_state_t;

  localparam logic [5:0] LEFT_TOP_IDX   = 6'd15;
  localparam logic [5:0] CORNER_IDX     = 6'd16;
  localparam logic [5:0] ABOVE_LEFT_IDX = 6'd17;

  typedef struct packed {
    logic [5:0] lo;
    logic [5:0] hi;
  } idx_rng_t;

  // Unsupported sizes fall back to the 32x32 range.
  function automatic idx_rng_t tu_range(input logic [3:0] tu);
    idx_rng_t   r;
    logic [5:0] n2;
    case (tu)
      4'd1:    n2 = 6'd2;
      4'd2:    n2 = 6'd4;
      4'd4:    n2 = 6'd8;
      default: n2 = 6'd16;
    endcase
    r.lo = LEFT_TOP_IDX + 6'd1 - n2;
    r.hi = ABOVE_LEFT_IDX - 6'd1 + n2;
    return r;
  endfunction

  function automatic logic [32:0] range_mask(input idx_rng_t r);
    logic [32:0] m;
    for (int i = 0; i < 33; i++)
      m[i] = (6'(i) >= r.lo) && (6'(i) <= r.hi);
    return m;
  endfunction

endpackage

// File: rtl/vc8000d_g2_hevc_flag_prio_enc.sv
// Masked lowest-set-bit encoder over the 33-bit neighbor flag vector.
// any is high when at least one masked bit is set.
module vc8000d_g2_hevc_flag_prio_enc (
  input  logic [32:0] flags,
  input  logic [32:0] mask,
  output logic [5:0]  idx,
  output logic        any
);

  logic [32:0] m;

  always_comb begin
    m   = flags & mask;
    idx = '0;
    for (int i = 32; i >= 0; i--)
      if (m[i]) idx = 6'(i);
    any = |m;
  end

endmodule

// File: rtl/vc8000d_g2_hevc_ref_sample_subst_lu.sv
// HEVC luma intra reference sample substitution, streamed per 4-sample unit.
// Define VC8000D_REF_SUBST_STATS_EN to add the subst_cnt output.
module vc8000d_g2_hevc_ref_sample_subst_lu
  import vc8000d_g2_hevc_intra_pkg::*;
#(
  parameter int PW  = 10,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [32:0]     neighbor_flags,
  input  logic [3:0]      tu_size_4x4,
  input  logic [3:0]      bit_depth,
  output logic            rd_req,
  output logic [5:0]      rd_idx,
  input  logic [4*PW-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*PW-1:0] out_data,
  output logic [5:0]      out_idx,
  output logic            out_last
`ifdef VC8000D_REF_SUBST_STATS_EN
  ,
  output logic [5:0]      subst_cnt
`endif
);

  subst_state_t    state, nxt;
  idx_rng_t        rng;
  logic [32:0]     mask;
  logic [5:0]      f;
  logic            any;

  logic [32:0]     flags_q;
  logic [5:0]      end_q;
  logic [5:0]      cur;
  logic [5:0]      f_q;
  logic [3:0]      bd_q;
  logic            none_q;
  logic [1:0]      wcnt;
  logic [PW-1:0]   last_reg;
  logic [4*PW-1:0] data_q;
  logic [5:0]      idx_q;
  logic            last_q;

  logic            acc;
  logic            rd_done;
  logic            avail;
  logic [PW-1:0]   dflt;
  logic [PW-1:0]   lane0;
  logic [PW-1:0]   lane3;
  logic            ld;
  logic [4*PW-1:0] ld_data;
  logic [PW-1:0]   ld_last;

  assign rng     = tu_range(tu_size_4x4);
  assign mask    = range_mask(rng);
  assign acc     = start_valid && (state == IDLE);
  assign rd_done = wcnt == 2'(LAT);
  assign avail   = flags_q[cur];
  assign dflt    = {{(PW-1){1'b0}}, 1'b1} << (bd_q - 4'd1);
  assign lane0   = rd_data[PW-1:0];
  assign lane3   = rd_data[4*PW-1 -: PW];

  assign start_ready = state == IDLE;
  assign out_valid   = state == HOLD;
  assign out_last    = (state == HOLD) && last_q;
  assign out_data    = data_q;
  assign out_idx     = idx_q;

  vc8000d_g2_hevc_flag_prio_enc u_enc (
    .flags (neighbor_flags),
    .mask  (mask),
    .idx   (f),
    .any   (any)
  );

  always_comb begin
    nxt     = state;
    rd_req  = 1'b0;
    rd_idx  = cur;
    ld      = 1'b0;
    ld_data = {4{last_reg}};
    ld_last = last_reg;
    unique case (state)
      IDLE: begin
        if (start_valid)
          nxt = any ? PRIME : NONE;
      end
      NONE: begin
        ld      = 1'b1;
        ld_data = {4{dflt}};
        nxt     = HOLD;
      end
      PRIME: begin
        rd_idx = f_q;
        rd_req = wcnt == 2'd0;
        if (rd_done)
          nxt = WALK;
      end
      WALK: begin
        if (!avail) begin
          ld  = 1'b1;
          nxt = HOLD;
        end else begin
          rd_req = wcnt == 2'd0;
          if (rd_done) begin
            ld  = 1'b1;
            nxt = HOLD;
            // the corner unit holds a single sample in lane0
            if (cur == CORNER_IDX) begin
              ld_data = {4{lane0}};
              ld_last = lane0;
            end else begin
              ld_data = rd_data;
              ld_last = lane3;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready)
          nxt = last_q ? IDLE : (none_q ? NONE : WALK);
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef VC8000D_REF_SUBST_STATS_EN
  logic [5:0] cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      flags_q  <= '0;
      end_q    <= '0;
      cur      <= '0;
      f_q      <= '0;
      bd_q     <= '0;
      none_q   <= 1'b0;
      wcnt     <= '0;
      last_reg <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
`ifdef VC8000D_REF_SUBST_STATS_EN
      cnt_q     <= '0;
      subst_cnt <= '0;
`endif
    end else begin
      state <= nxt;
      if (acc) begin
        flags_q <= neighbor_flags & mask;
        end_q   <= rng.hi;
        cur     <= rng.lo;
        f_q     <= f;
        bd_q    <= bit_depth;
        none_q  <= !any;
        wcnt    <= '0;
`ifdef VC8000D_REF_SUBST_STATS_EN
        cnt_q   <= '0;
`endif
      end
      if (rd_req || (wcnt != 2'd0))
        wcnt <= rd_done ? 2'd0 : wcnt + 2'd1;
      if ((state == PRIME) && rd_done)
        last_reg <= lane0;
      if (ld) begin
        data_q   <= ld_data;
        idx_q    <= cur;
        last_q   <= cur == end_q;
        last_reg <= ld_last;
      end
      if ((state == HOLD) && out_ready && !last_q)
        cur <= cur + 6'd1;
`ifdef VC8000D_REF_SUBST_STATS_EN
      if (ld && ((state == NONE) || !avail))
        cnt_q <= cnt_q + 6'd1;
      if ((state == HOLD) && out_ready && last_q)
        subst_cnt <= cnt_q;
`endif
    end
  end

endmodule

// File: tb/tb_vc8000d_g2_hevc_ref_sample_subst_lu.sv
// Self-checking bench: directed table, random jobs against a sample-level
// substitution model, and a reset-during-output sequence.
module tb_vc8000d_g2_hevc_ref_sample_subst_lu;

  localparam int PW  = 10;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start_valid = 1'b0;
  logic            start_ready;
  logic [32:0]     neighbor_flags = '0;
  logic [3:0]      tu_size_4x4 = 4'd1;
  logic [3:0]      bit_depth = 4'd8;
  logic            rd_req;
  logic [5:0]      rd_idx;
  logic [4*PW-1:0] rd_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4*PW-1:0] out_data;
  logic [5:0]      out_idx;
  logic            out_last;
`ifdef VC8000D_REF_SUBST_STATS_EN
  logic [5:0]      subst_cnt;
`endif

  always #5 clk = ~clk;

  vc8000d_g2_hevc_ref_sample_subst_lu #(.PW(PW), .LAT(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .neighbor_flags (neighbor_flags),
    .tu_size_4x4    (tu_size_4x4),
    .bit_depth      (bit_depth),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_data        (rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_last       (out_last)
`ifdef VC8000D_REF_SUBST_STATS_EN
    ,
    .subst_cnt      (subst_cnt)
`endif
  );

  // Neighbor buffer with fixed read latency
  logic [4*PW-1:0] mem [0:32];
  logic [4*PW-1:0] p1 = '0;
  logic [4*PW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= mem[rd_idx];
    p2 <= p1;
  end
  assign rd_data = (LAT == 1) ? p1 : p2;

  int rd_cnt = 0;
  int stall_rd = 0;
  always @(posedge clk) begin
    if (!reset) begin
      if (rd_req) rd_cnt <= rd_cnt + 1;
      if (rd_req && out_valid && !out_ready) stall_rd <= stall_rd + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: flatten to samples, substitute per sample, regroup to units
  logic [4*PW-1:0] exp_data[$];
  logic [5:0]      exp_idx[$];
  int              exp_sub;
  int              exp_av;

  task automatic build_exp(input logic [32:0] fl, input logic [3:0] tu,
                           input logic [3:0] bd);
    int n, s, e, pos, k;
    logic [PW-1:0]   smp[$];
    bit              av[$];
    logic [4*PW-1:0] w;
    logic [PW-1:0]   one;
    n = (tu == 1 || tu == 2 || tu == 4) ? int'(tu) : 8;
    s = 16 - 2 * n;
    e = 16 + 2 * n;
    exp_data.delete();
    exp_idx.delete();
    exp_sub = 0;
    exp_av = 0;
    for (int u = s; u <= e; u++) begin
      if (fl[u]) exp_av++;
      else exp_sub++;
      w = mem[u];
      for (int l = 0; l < ((u == 16) ? 1 : 4); l++) begin
        smp.push_back(w[l*PW +: PW]);
        av.push_back(fl[u]);
      end
    end
    k = -1;
    for (int i = 0; i < smp.size(); i++)
      if (av[i] && k < 0) k = i;
    one = 1;
    if (k < 0) begin
      for (int i = 0; i < smp.size(); i++) smp[i] = one << (bd - 1);
    end else begin
      if (!av[0]) smp[0] = smp[k];
      for (int i = 1; i < smp.size(); i++)
        if (!av[i]) smp[i] = smp[i-1];
    end
    pos = 0;
    for (int u = s; u <= e; u++) begin
      if (u == 16) begin
        w = {4{smp[pos]}};
        pos++;
      end else begin
        for (int l = 0; l < 4; l++) w[l*PW +: PW] = smp[pos+l];
        pos += 4;
      end
      exp_data.push_back(w);
      exp_idx.push_back(6'(u));
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int u = 0; u < 33; u++) begin
      if (kind == 1)
        for (int l = 0; l < 4; l++) mem[u][l*PW +: PW] = PW'(4 * u + l);
      else
        mem[u] = (4*PW)'({$urandom, $urandom});
    end
    if (kind == 2) begin
      for (int l = 0; l < 4; l++) mem[17][l*PW +: PW] = PW'(10 + l);
    end
  endtask

  task automatic run_job(input logic [32:0] fl, input logic [3:0] tu,
                         input logic [3:0] bd, input int rmode,
                         input int exp_u, input int exp_rd,
                         input string tag);
    int got, rd0, st0, want_u, want_rd;
    bit done, held;
    logic [4*PW-1:0] hd;
    logic [5:0] hi;
    build_exp(fl, tu, bd);
    want_u  = (exp_u >= 0) ? exp_u : exp_data.size();
    want_rd = (exp_rd >= 0) ? exp_rd : ((exp_av > 0) ? exp_av + 1 : 0);
    @(negedge clk);
    chk({tag, " idle_ready"}, 64'(start_ready), 64'd1);
    neighbor_flags = fl;
    tu_size_4x4 = tu;
    bit_depth = bd;
    start_valid = 1'b1;
    rd0 = rd_cnt;
    st0 = stall_rd;
    @(negedge clk);
    start_valid = 1'b0;
    chk({tag, " ready_drop"}, 64'(start_ready), 64'd0);
    got = 0;
    done = 0;
    held = 0;
    hd = '0;
    hi = '0;
    for (int c = 0; c < 4000 && !done; c++) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = c[0];
        default: out_ready = 1'($urandom % 2);
      endcase
      if (held && out_valid) begin
        chk({tag, " stall_data"}, 64'(out_data), 64'(hd));
        chk({tag, " stall_idx"}, 64'(out_idx), 64'(hi));
      end
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (got < exp_data.size()) begin
            chk($sformatf("%s data[%0d]", tag, got), 64'(out_data),
                64'(exp_data[got]));
            chk($sformatf("%s idx[%0d]", tag, got), 64'(out_idx),
                64'(exp_idx[got]));
            chk($sformatf("%s last[%0d]", tag, got), 64'(out_last),
                64'(got == exp_data.size() - 1));
          end else begin
            chk({tag, " extra_unit"}, 64'(got), 64'(exp_data.size() - 1));
          end
          got++;
          if (out_last) done = 1;
        end else begin
          held = 1;
          hd = out_data;
          hi = out_idx;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, " completed"}, 64'(done), 64'd1);
    chk({tag, " units"}, 64'(got), 64'(want_u));
    chk({tag, " reads"}, 64'(rd_cnt - rd0), 64'(want_rd));
    chk({tag, " stall_reads"}, 64'(stall_rd - st0), 64'd0);
    chk({tag, " back_idle"}, 64'(start_ready), 64'd1);
    chk({tag, " valid_low"}, 64'(out_valid), 64'd0);
`ifdef VC8000D_REF_SUBST_STATS_EN
    chk({tag, " subst_cnt"}, 64'(subst_cnt), 64'(exp_sub));
`endif
  endtask

  typedef struct {
    logic [32:0] fl;
    logic [3:0]  tu;
    logic [3:0]  bd;
    int          rmode;
    int          memk;
    int          exp_u;
    int          exp_rd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [3:0] tus[6];
    tbl[0] = '{33'h0, 4'd1, 4'd8, 0, 0, 5, 0};
    tbl[1] = '{33'h0_0002_0000, 4'd1, 4'd8, 0, 2, 5, 2};
    tbl[2] = '{33'h0_001F_F000, 4'd2, 4'd10, 0, 1, 9, 10};
    tbl[3] = '{33'h0_AAAA_AAAA, 4'd8, 4'd10, 1, 0, 33, 17};
    tbl[4] = '{33'h1FFFF00 & ~33'h1910300, 4'd4, 4'd10, 2, 0, 17, 12};
    tbl[5] = '{33'h1_2345_6789, 4'd3, 4'd9, 2, 0, 33, -1};
    tbl[6] = '{33'h0, 4'd8, 4'd10, 1, 0, 33, 0};
    tus = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};
    fill_mem(0);

    repeat (3) @(negedge clk);
    chk("rst start_ready", 64'(start_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst rd_req", 64'(rd_req), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_idx", 64'(out_idx), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fill_mem(tbl[i].memk);
      run_job(tbl[i].fl, tbl[i].tu, tbl[i].bd, tbl[i].rmode,
              tbl[i].exp_u, tbl[i].exp_rd, $sformatf("vec%0d", i));
    end

    for (int j = 0; j < 12; j++) begin
      logic [32:0] fl;
      case ($urandom % 4)
        0: fl = '0;
        1: fl = '1;
        default: fl = 33'({$urandom, $urandom});
      endcase
      fill_mem(0);
      run_job(fl, tus[$urandom % 6], 4'(8 + $urandom % 3), $urandom % 3,
              -1, -1, $sformatf("rnd%0d", j));
    end

    // reset while a unit is waiting in the output register
    fill_mem(1);
    @(negedge clk);
    neighbor_flags = 33'h0_001F_F000;
    tu_size_4x4 = 4'd2;
    bit_depth = 4'd10;
    start_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    for (int c = 0; c < 50 && !out_valid; c++) @(negedge clk);
    chk("hold reached", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst start_ready", 64'(start_ready), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst quiet", 64'(out_valid), 64'd0);
    run_job(33'h0_0015_5000, 4'd2, 4'd10, 0, 9, -1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
